// File: rtl/edid_pkg.sv
// Shared types and constants for the E-DDC/EDID responder and its RAM.
`default_nettype none

package edid_pkg;

  localparam int         BLOCK_BYTES   = 128;
  localparam logic [6:0] DDC_ADDR_EDID = 7'h50;
  localparam logic [6:0] DDC_ADDR_SEG  = 7'h30;

  typedef enum logic [1:0] {
    TGT_EDID  = 2'd0,
    TGT_SEG   = 2'd1,
    TGT_OTHER = 2'd2
  } tgt_e;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_FETCH   = 2'd1,
    RD_PRESENT = 2'd2
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/edid_ram.sv
// EDID storage: DEPTH x 8 synchronous RAM, one write port and one read port.
`default_nettype none

module edid_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Read-before-write on a same-address collision; the caller invalidates such reads.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

`default_nettype wire

// File: rtl/ddc_edid_responder.sv
// E-DDC/EDID responder: serves EDID bytes to an i2c_slave byte stream, with
// segment pointer, optional master writes and a host load port.
`default_nettype none

module ddc_edid_responder
  import edid_pkg::*;
#(
  parameter int         NUM_BLOCKS   = 2,
  parameter logic [6:0] ADDR_EDID    = DDC_ADDR_EDID,
  parameter logic [6:0] ADDR_SEG     = DDC_ADDR_SEG,
  parameter bit         WRITE_ENABLE = 1'b0,
  localparam int        DEPTH        = NUM_BLOCKS * BLOCK_BYTES,
  localparam int        AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [7:0]    sl_data_in,
  output logic          sl_data_in_valid,
  input  logic          sl_data_in_ready,
  output logic          sl_data_in_last,
  input  logic [7:0]    sl_data_out,
  input  logic          sl_data_out_valid,
  output logic          sl_data_out_ready,
  input  logic          sl_data_out_last,
  input  logic [6:0]    sl_bus_address,
  input  logic          sl_bus_addressed,
  input  logic          sl_bus_active,
  output logic          sl_enable,
  output logic [6:0]    sl_device_address,
  output logic [6:0]    sl_device_address_mask,
  output logic          sl_release_bus,
  input  logic          edid_valid,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic          wr_collision
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  rd_state_e   state_q, state_d;
  logic [7:0]  offset_q, offset_d;
  logic [7:0]  segment_q, segment_d;
  logic        first_byte_q, first_byte_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        collision_q;
  logic        active_q, addressed_q;
  logic        rd_in_range_q;

  tgt_e        tgt;
  logic        wr_hs, rd_hs, active_fall, addressed_rise, inval;
  logic [15:0] cur_addr, rd_addr;
  logic        cur_in_range, load_in_range;
  logic        master_we, ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]  ram_wdata, ram_rdata;

  assign sl_data_in             = data_q;
  assign sl_data_in_valid       = valid_q;
  assign sl_data_in_last        = 1'b0;
  assign sl_data_out_ready      = 1'b1;
  assign sl_enable              = edid_valid;
  assign sl_device_address      = ADDR_EDID;
  assign sl_device_address_mask = ~(ADDR_EDID ^ ADDR_SEG);
  assign sl_release_bus         = 1'b0;
  assign wr_collision           = collision_q;

  always_comb begin
    tgt = TGT_OTHER;
    if (sl_bus_address == ADDR_EDID)     tgt = TGT_EDID;
    else if (sl_bus_address == ADDR_SEG) tgt = TGT_SEG;
  end

  assign wr_hs          = sl_data_out_valid;
  assign rd_hs          = valid_q & sl_data_in_ready;
  assign active_fall    = active_q & ~sl_bus_active;
  assign addressed_rise = ~addressed_q & sl_bus_addressed;
  assign cur_addr       = {segment_q, offset_q};
  assign cur_in_range   = {1'b0, cur_addr} < DEPTH_W;
  assign load_in_range  = 17'(load_addr) < DEPTH_W;

  // Host load wins the single write port; the master byte is then dropped.
  assign master_we = wr_hs & (tgt == TGT_EDID) & ~first_byte_q & WRITE_ENABLE & cur_in_range;
  assign ram_we    = (load_we & load_in_range) | (master_we & ~load_we);
  assign ram_waddr = load_we ? load_addr : cur_addr[AW-1:0];
  assign ram_wdata = load_we ? load_data : sl_data_out;

  always_comb begin
    offset_d     = offset_q;
    segment_d    = segment_q;
    first_byte_d = first_byte_q;
    inval        = 1'b0;
    if (rd_hs && tgt == TGT_EDID) offset_d = offset_q + 8'd1;
    if (wr_hs) begin
      first_byte_d = sl_data_out_last;
      case (tgt)
        TGT_EDID: begin
          offset_d = first_byte_q ? sl_data_out : offset_q + 8'd1;
          inval    = 1'b1;
        end
        TGT_SEG: begin
          segment_d = sl_data_out;
          inval     = 1'b1;
        end
        default: ;
      endcase
    end
    if (active_fall) segment_d = 8'd0;
    if (!sl_bus_active || addressed_rise) first_byte_d = 1'b1;
    if (active_fall || addressed_rise || !edid_valid) inval = 1'b1;
    if (ram_we && (ram_waddr == cur_addr[AW-1:0] || ram_waddr == rd_addr[AW-1:0])) inval = 1'b1;
  end

  // The RAM is addressed with the next-cycle pointer so FETCH sees the right byte.
  assign rd_addr = {segment_d, offset_d};

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    case (state_q)
      RD_IDLE: if (edid_valid) state_d = RD_FETCH;
      RD_FETCH: begin
        data_d  = (tgt == TGT_EDID && rd_in_range_q) ? ram_rdata : 8'hFF;
        valid_d = 1'b1;
        state_d = RD_PRESENT;
      end
      RD_PRESENT: if (rd_hs) begin
        valid_d = 1'b0;
        state_d = RD_FETCH;
      end
      default: state_d = RD_IDLE;
    endcase
    if (inval) begin
      state_d = RD_IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RD_IDLE;
      offset_q      <= 8'd0;
      segment_q     <= 8'd0;
      first_byte_q  <= 1'b1;
      data_q        <= 8'd0;
      valid_q       <= 1'b0;
      collision_q   <= 1'b0;
      active_q      <= 1'b0;
      addressed_q   <= 1'b0;
      rd_in_range_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      segment_q     <= segment_d;
      first_byte_q  <= first_byte_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      collision_q   <= master_we & load_we;
      active_q      <= sl_bus_active;
      addressed_q   <= sl_bus_addressed;
      rd_in_range_q <= {1'b0, rd_addr} < DEPTH_W;
    end
  end

  edid_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr[AW-1:0]),
    .rdata_o (ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_ddc_edid_responder.sv
// Self-checking bench for ddc_edid_responder (4 blocks, master writes enabled).
`default_nettype none

module tb_ddc_edid_responder;

  localparam int         NB    = 4;
  localparam int         DEPTH = NB * 128;
  localparam int         AW    = 9;
  localparam logic [6:0] A_EDID  = 7'h50;
  localparam logic [6:0] A_SEG   = 7'h30;
  localparam logic [6:0] A_OTHER = 7'h70;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    sl_data_in;
  logic          sl_data_in_valid;
  logic          sl_data_in_ready = 1'b0;
  logic          sl_data_in_last;
  logic [7:0]    sl_data_out = 8'd0;
  logic          sl_data_out_valid = 1'b0;
  logic          sl_data_out_ready;
  logic          sl_data_out_last = 1'b0;
  logic [6:0]    sl_bus_address = 7'h50;
  logic          sl_bus_addressed = 1'b0;
  logic          sl_bus_active = 1'b0;
  logic          sl_enable;
  logic [6:0]    sl_device_address;
  logic [6:0]    sl_device_address_mask;
  logic          sl_release_bus;
  logic          edid_valid = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = 8'd0;
  logic          wr_collision;

  always #5 clk = ~clk;

  ddc_edid_responder #(
    .NUM_BLOCKS   (NB),
    .ADDR_EDID    (A_EDID),
    .ADDR_SEG     (A_SEG),
    .WRITE_ENABLE (1'b1)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .sl_data_in             (sl_data_in),
    .sl_data_in_valid       (sl_data_in_valid),
    .sl_data_in_ready       (sl_data_in_ready),
    .sl_data_in_last        (sl_data_in_last),
    .sl_data_out            (sl_data_out),
    .sl_data_out_valid      (sl_data_out_valid),
    .sl_data_out_ready      (sl_data_out_ready),
    .sl_data_out_last       (sl_data_out_last),
    .sl_bus_address         (sl_bus_address),
    .sl_bus_addressed       (sl_bus_addressed),
    .sl_bus_active          (sl_bus_active),
    .sl_enable              (sl_enable),
    .sl_device_address      (sl_device_address),
    .sl_device_address_mask (sl_device_address_mask),
    .sl_release_bus         (sl_release_bus),
    .edid_valid             (edid_valid),
    .load_we                (load_we),
    .load_addr              (load_addr),
    .load_data              (load_data),
    .wr_collision           (wr_collision)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] exp_q [$];

  typedef struct {
    logic       use_seg;
    logic [7:0] seg;
    logic [7:0] off;
    logic [7:0] e0, e1, e2;
  } rd_vec_t;

  rd_vec_t vecs [6];

  function automatic logic [7:0] pattern(input int i);
    logic [15:0] a;
    a = 16'(i);
    return a[7:0] ^ (a[8] ? 8'hA5 : 8'h00);
  endfunction

  function automatic logic [7:0] mget(input logic [7:0] seg, input logic [7:0] off);
    logic [15:0] a;
    a = {seg, off};
    return (int'(a) < DEPTH) ? model[a[AW-1:0]] : 8'hFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [6:0] a);
    sl_bus_active    = 1'b1;
    sl_bus_addressed = 1'b0;
    sl_bus_address   = a;
    step();
    sl_bus_addressed = 1'b1;
    step();
  endtask

  task automatic stop();
    sl_bus_addressed = 1'b0;
    sl_bus_active    = 1'b0;
    step();
    step();
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic last, input logic lw,
                         input logic [AW-1:0] la, input logic [7:0] ld);
    sl_data_out       = d;
    sl_data_out_last  = last;
    sl_data_out_valid = 1'b1;
    load_we           = lw;
    load_addr         = la;
    load_data         = ld;
    step();
    sl_data_out_valid = 1'b0;
    sl_data_out_last  = 1'b0;
    load_we           = 1'b0;
  endtask

  task automatic rd_one(input string name);
    int         t;
    logic [7:0] e;
    t = 0;
    while (!sl_data_in_valid && t < 20) begin
      step();
      t++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    if (!sl_data_in_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: valid timeout, got 0, required 1", name);
      return;
    end
    check(name, 32'(sl_data_in), 32'(e));
    step();
    check({name, " hold"}, 32'(sl_data_in), 32'(e));
    sl_data_in_ready = 1'b1;
    step();
    sl_data_in_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'h10, 8'h10, 8'h11, 8'h12};
    vecs[1] = '{1'b1, 8'h01, 8'h05, 8'hA0, 8'hA3, 8'hA2};
    vecs[2] = '{1'b1, 8'h01, 8'hFE, 8'h5B, 8'h5A, 8'hA5};
    vecs[3] = '{1'b0, 8'h00, 8'hFE, 8'hFE, 8'hFF, 8'h00};
    vecs[4] = '{1'b1, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    vecs[5] = '{1'b1, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    step();
    step();
    check("reset data_in", 32'(sl_data_in), 32'h00);
    check("reset valid", 32'(sl_data_in_valid), 32'h0);
    check("reset collision", 32'(wr_collision), 32'h0);
    check("enable follows edid_valid", 32'(sl_enable), 32'h0);
    check("device address", 32'(sl_device_address), 32'h50);
    check("address mask", 32'(sl_device_address_mask), 32'h1F);
    check("tied outputs", 32'({sl_data_in_last, sl_release_bus, sl_data_out_ready}), 32'h1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) begin
      model[i]  = pattern(i);
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = pattern(i);
      step();
    end
    load_we    = 1'b0;
    edid_valid = 1'b1;
    step();
    check("enable high", 32'(sl_enable), 32'h1);

    for (int i = 0; i < 6; i++) begin
      stop();
      if (vecs[i].use_seg) begin
        start(A_SEG);
        wr_byte(vecs[i].seg, 1'b1, 1'b0, '0, 8'h00);
      end
      start(A_EDID);
      wr_byte(vecs[i].off, 1'b1, 1'b0, '0, 8'h00);
      start(A_EDID);
      exp_q.push_back(vecs[i].e0);
      exp_q.push_back(vecs[i].e1);
      exp_q.push_back(vecs[i].e2);
      rd_one($sformatf("vec%0d b0", i));
      rd_one($sformatf("vec%0d b1", i));
      rd_one($sformatf("vec%0d b2", i));
      if (i == 2) begin
        // Segment persists across repeated START: next byte is 0x101.
        start(A_EDID);
        exp_q.push_back(mget(8'h01, 8'h01));
        rd_one("wrap segment kept");
      end
      if (i == 0) begin
        // NAK after three bytes: offset must stand at 0x13.
        start(A_EDID);
        exp_q.push_back(8'h13);
        rd_one("after NAK");
      end
    end

    stop();
    start(A_SEG);
    wr_byte(8'h01, 1'b1, 1'b0, '0, 8'h00);
    start(A_EDID);
    wr_byte(8'h05, 1'b1, 1'b0, '0, 8'h00);
    start(A_EDID);
    exp_q.push_back(mget(8'h01, 8'h05));
    rd_one("seg1 read");
    stop();
    start(A_EDID);
    wr_byte(8'h05, 1'b1, 1'b0, '0, 8'h00);
    start(A_EDID);
    exp_q.push_back(mget(8'h00, 8'h05));
    rd_one("seg cleared by STOP");

    stop();
    start(A_OTHER);
    exp_q.push_back(8'hFF);
    rd_one("other read");
    stop();
    start(A_OTHER);
    wr_byte(8'h00, 1'b0, 1'b0, '0, 8'h00);
    wr_byte(8'h77, 1'b1, 1'b0, '0, 8'h00);
    stop();
    start(A_EDID);
    wr_byte(8'h00, 1'b1, 1'b0, '0, 8'h00);
    start(A_EDID);
    exp_q.push_back(model[0]);
    rd_one("other write ignored");

    stop();
    start(A_EDID);
    wr_byte(8'h20, 1'b0, 1'b0, '0, 8'h00);
    wr_byte(8'hAA, 1'b0, 1'b0, '0, 8'h00);
    wr_byte(8'hBB, 1'b1, 1'b0, '0, 8'h00);
    model[9'h020] = 8'hAA;
    model[9'h021] = 8'hBB;
    start(A_EDID);
    wr_byte(8'h20, 1'b1, 1'b0, '0, 8'h00);
    start(A_EDID);
    exp_q.push_back(model[9'h020]);
    exp_q.push_back(model[9'h021]);
    rd_one("master write 0x20");
    rd_one("master write 0x21");

    stop();
    start(A_EDID);
    wr_byte(8'h30, 1'b0, 1'b0, '0, 8'h00);
    wr_byte(8'hCC, 1'b0, 1'b1, 9'h030, 8'h99);
    check("collision pulse", 32'(wr_collision), 32'h1);
    wr_byte(8'hDD, 1'b1, 1'b0, '0, 8'h00);
    check("collision one cycle", 32'(wr_collision), 32'h0);
    model[9'h030] = 8'h99;
    model[9'h031] = 8'hDD;
    start(A_EDID);
    wr_byte(8'h30, 1'b1, 1'b0, '0, 8'h00);
    start(A_EDID);
    exp_q.push_back(model[9'h030]);
    exp_q.push_back(model[9'h031]);
    rd_one("host wins 0x30");
    rd_one("offset advanced 0x31");

    edid_valid = 1'b0;
    step();
    step();
    check("invalid enable", 32'(sl_enable), 32'h0);
    check("invalid no data valid", 32'(sl_data_in_valid), 32'h0);
    edid_valid = 1'b1;

    stop();
    start(A_SEG);
    wr_byte(8'h01, 1'b1, 1'b0, '0, 8'h00);
    start(A_EDID);
    wr_byte(8'h40, 1'b1, 1'b0, '0, 8'h00);
    start(A_EDID);
    begin
      int t;
      t = 0;
      while (!sl_data_in_valid && t < 20) begin
        step();
        t++;
      end
      check("pre-reset valid", 32'(sl_data_in_valid), 32'h1);
      check("pre-reset data", 32'(sl_data_in), 32'(mget(8'h01, 8'h40)));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset data_in", 32'(sl_data_in), 32'h00);
    check("async reset valid", 32'(sl_data_in_valid), 32'h0);
    check("async reset collision", 32'(wr_collision), 32'h0);
    @(posedge clk);
    #1;
    sl_bus_addressed = 1'b0;
    rst_n = 1'b1;
    step();
    start(A_EDID);
    exp_q.push_back(mget(8'h00, 8'h00));
    rd_one("post-reset pointers");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ddc_edid_responder.md
# ddc_edid_responder

Parametrised E-DDC/EDID responder that sits between the byte-stream host interface of `i2c_slave` and an internal multi-block EDID memory. It serves EDID reads at the DDC address, supports the E-DDC segment pointer for EDIDs larger than 256 bytes, and optionally accepts master writes into the memory. A host load port fills the memory at runtime. `edid_valid` gates the slave's `enable`.

## Interface
- `NUM_BLOCKS`, 2: number of 128-byte EDID blocks, 1..256; `DEPTH = NUM_BLOCKS*128`, `AW = $clog2(DEPTH)`
- `ADDR_EDID`, 7'h50: DDC data address
- `ADDR_SEG`, 7'h30: E-DDC segment pointer address
- `WRITE_ENABLE`, 0: 1 = master writes after the offset byte store into memory; 0 = they are discarded
---
- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `sl_data_in` out 8: read byte to `i2c_slave` `data_in`
- `sl_data_in_valid` out 1 / `sl_data_in_ready` in 1 / `sl_data_in_last` out 1 (tied 0)
- `sl_data_out` in 8: written byte from `i2c_slave` `data_out`
- `sl_data_out_valid` in 1 / `sl_data_out_ready` out 1 (tied 1) / `sl_data_out_last` in 1
- `sl_bus_address` in 7 / `sl_bus_addressed` in 1 / `sl_bus_active` in 1: slave status
- `sl_enable` out 1: equals `edid_valid`
- `sl_device_address` out 7: `ADDR_EDID`
- `sl_device_address_mask` out 7: `~(ADDR_EDID ^ ADDR_SEG)`
- `sl_release_bus` out 1: tied 0
- `edid_valid` in 1: host asserts once memory is loaded
- `load_we` in 1 / `load_addr` in AW / `load_data` in 8: host memory write port
- `wr_collision` out 1: one-cycle pulse when a master write is dropped

## Operation
- Target decode on `sl_bus_address`: `ADDR_EDID` → EDID, `ADDR_SEG` → SEG. Any other address the mask admits → OTHER: writes ignored, reads return 8'hFF.
- `first_byte` flag is set on reset, while `sl_bus_active`=0, on a rising edge of `sl_bus_addressed`, and after a handshake with `sl_data_out_last`=1. It is cleared by any write handshake.
- EDID write:
  - With `first_byte` set, the byte loads `offset[7:0]`.
  - Later bytes write memory at `{segment,offset}` if `WRITE_ENABLE` is set and the address is below DEPTH; `offset` increments either way.
- SEG write: the byte loads `segment[7:0]`. `segment` clears to 0 when `sl_bus_active` falls (STOP). It persists across repeated START.
- EDID read:
  - Byte address is `{segment,offset}`; if it is at or above DEPTH, the data is 8'hFF.
  - `offset` increments on each `sl_data_in` handshake and wraps 8'hFF→8'h00; `segment` does not change.
- Read prefetch FSM:
  - IDLE: if `edid_valid` is set, issue the RAM read and go to FETCH.
  - FETCH: RAM data lands in the output register; assert valid; go to PRESENT.
  - PRESENT: on handshake, increment `offset` and go to FETCH.
  - Invalidate → IDLE on any of: offset or segment write, a memory write to the presented address, `sl_bus_active` fall, `sl_bus_addressed` rise, or `edid_valid` low.
- Write port arbitration:
  - `load_we` has priority over a master write in the same cycle.
  - The master byte is dropped, `offset` still increments, and `wr_collision` pulses.
- Memory is a single-write, single-read synchronous RAM; it is not reset.

## Timing
- Reset values: `sl_data_in`=0, `sl_data_in_valid`=0, `wr_collision`=0, FSM=IDLE, `offset`=0, `segment`=0, `first_byte`=1.
- Read latency: `sl_data_in_valid` rises 2 cycles after an invalidate (IDLE→FETCH→PRESENT).
- Back-to-back reads: after a handshake, valid drops for 1 cycle and the next byte is valid 2 cycles later. I2C byte time hides this.
- `sl_data_in` is stable while valid is high and ready is low.
- The write handshake is accepted every cycle.
- Simultaneous invalidate and handshake: the handshake increments `offset`, then the invalidate applies.
- `rst_n` asserted mid-transaction: all state returns to reset values immediately. Memory contents are retained.

## Structure
- Shared package `edid_pkg`: block size 128, default addresses 7'h50/7'h30, target enum {TGT_EDID, TGT_SEG, TGT_OTHER}, FSM enum {RD_IDLE, RD_FETCH, RD_PRESENT}.
- One sub-module, `edid_ram`: DEPTH×8 synchronous RAM with 1 write and 1 read port.
- `i2c_slave` is instantiated by the parent, not inside this block.

## Test plan
- Load 256 bytes with byte[i]=i. Master write 0x50: {0x10}, repeated START, read 3 bytes → 0x10, 0x11, 0x12; NAK; no further `offset` increment.
- NUM_BLOCKS=4. Write 0x30: {0x01}, Sr, 0x50: {0x05}, Sr, read → memory[0x105]. After STOP, write 0x50: {0x05} + read → memory[0x005].
- Offset 0xFE, read 3 → bytes at 0x0FE, 0x0FF, 0x000; `segment` unchanged.
- NUM_BLOCKS=1, segment=1 → reads return 0xFF. Address 0x70 (mask-admitted) read → 0xFF; write → memory unchanged.
- WRITE_ENABLE=1: write 0x50: {0x20, 0xAA, 0xBB} → mem[0x20]=0xAA, mem[0x21]=0xBB. Repeat with `load_we` on the 0xAA cycle → host data kept, `wr_collision`=1 for one cycle.
- `edid_valid`=0 → `sl_enable`=0, `sl_data_in_valid`=0. Assert `rst_n`=0 during a read → all outputs at reset values within the same cycle.
